// File: rtl/axi_lite_obi_bridge_pkg.sv
`default_nettype none
// ============================================================================
// axi_obi_bridge_pkg : shared types and constants for the AXI-Lite/OBI bridge
// Rev 1.0
// ============================================================================
package axi_obi_bridge_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_WR_REQ  = 3'd1;
    localparam state_t ST_WR_WAIT = 3'd2;
    localparam state_t ST_WR_RESP = 3'd3;
    localparam state_t ST_RD_REQ  = 3'd4;
    localparam state_t ST_RD_WAIT = 3'd5;
    localparam state_t ST_RD_RESP = 3'd6;

endpackage
`default_nettype wire

// File: rtl/axi_lite_obi_bridge_if.sv
`default_nettype none
// ============================================================================
// axi_lite_obi_bridge_if : AXI4-Lite slave channels plus OBI master channels
// Rev 1.0
// ============================================================================
interface axi_lite_obi_bridge_if #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32
);
    logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr;
    logic                        s_axi_awvalid;
    logic                        s_axi_awready;
    logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata;
    logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb;
    logic                        s_axi_wvalid;
    logic                        s_axi_wready;
    logic [1:0]                  s_axi_bresp;
    logic                        s_axi_bvalid;
    logic                        s_axi_bready;
    logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr;
    logic                        s_axi_arvalid;
    logic                        s_axi_arready;
    logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata;
    logic [1:0]                  s_axi_rresp;
    logic                        s_axi_rvalid;
    logic                        s_axi_rready;

    logic                        obi_req;
    logic                        obi_gnt;
    logic [AXI_ADDR_WIDTH-1:0]   obi_addr;
    logic                        obi_we;
    logic [AXI_DATA_WIDTH/8-1:0] obi_be;
    logic [AXI_DATA_WIDTH-1:0]   obi_wdata;
    logic                        obi_rvalid;
    logic [AXI_DATA_WIDTH-1:0]   obi_rdata;

    // Bridge side: AXI slave, OBI master
    modport slave (
        input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        input  s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
        output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
        output obi_req, obi_addr, obi_we, obi_be, obi_wdata,
        input  obi_gnt, obi_rvalid, obi_rdata
    );

    modport master (
        output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        output s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
        input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
        input  obi_req, obi_addr, obi_we, obi_be, obi_wdata,
        output obi_gnt, obi_rvalid, obi_rdata
    );
endinterface
`default_nettype wire

// File: rtl/axi_lite_obi_bridge_subtractor.sv
`default_nettype none
// ============================================================================
// axi_address_fix_subtractor : removes the window base, flags out-of-window
// Rev 1.0
// ============================================================================
module axi_address_fix_subtractor #(
    parameter int                        AXI_ADDR_WIDTH = 32,
    parameter logic [AXI_ADDR_WIDTH-1:0] ADDR_OFFSET    = 32'h4000_0000
) (
    input  wire logic [AXI_ADDR_WIDTH-1:0] i_addr,
    output logic      [AXI_ADDR_WIDTH-1:0] o_addr,
    output logic                           o_in_window
);
    logic [AXI_ADDR_WIDTH:0] w_diff;

    // The borrow out of the widened subtraction is exactly addr < ADDR_OFFSET
    assign w_diff      = {1'b0, i_addr} - {1'b0, ADDR_OFFSET};
    assign o_addr      = w_diff[AXI_ADDR_WIDTH-1:0];
    assign o_in_window = ~w_diff[AXI_ADDR_WIDTH];
endmodule
`default_nettype wire

// File: rtl/axi_lite_obi_bridge.sv
`default_nettype none
// ============================================================================
// axi_lite_obi_bridge : single-outstanding AXI4-Lite slave to OBI master bridge
// Rev 1.0
// ============================================================================
module axi_lite_obi_bridge
    import axi_obi_bridge_pkg::*;
#(
    parameter int                        AXI_ADDR_WIDTH = 32,
    parameter int                        AXI_DATA_WIDTH = 32,
    parameter logic [AXI_ADDR_WIDTH-1:0] ADDR_OFFSET    = 32'h4000_0000
) (
    input  wire logic             s_axi_aclk,
    input  wire logic             s_axi_aresetn,
    axi_lite_obi_bridge_if.slave  bus
);
    localparam int STRB_W = AXI_DATA_WIDTH / 8;

    state_t                    r_state;
    logic                      r_last_was_write;
    logic [AXI_ADDR_WIDTH-1:0] r_obi_addr;
    logic [AXI_DATA_WIDTH-1:0] r_obi_wdata;
    logic [STRB_W-1:0]         r_obi_be;
    logic                      r_obi_we;
    logic [1:0]                r_bresp;
    logic [1:0]                r_rresp;
    logic [AXI_DATA_WIDTH-1:0] r_rdata;

    logic                      w_idle;
    logic                      w_wr_elig;
    logic                      w_rd_elig;
    logic                      w_take_wr;
    logic                      w_take_rd;
    logic                      w_in_window;
    logic [AXI_ADDR_WIDTH-1:0] w_raw_addr;
    logic [AXI_ADDR_WIDTH-1:0] w_xlat_addr;

    // Readies are gated by reset so nothing is acknowledged while held in reset
    assign w_idle    = (r_state == ST_IDLE) && s_axi_aresetn;
    assign w_wr_elig = bus.s_axi_awvalid && bus.s_axi_wvalid;
    assign w_rd_elig = bus.s_axi_arvalid;
    assign w_take_wr = w_idle && w_wr_elig && (!w_rd_elig || !r_last_was_write);
    assign w_take_rd = w_idle && w_rd_elig && !w_take_wr;
    assign w_raw_addr = w_take_wr ? bus.s_axi_awaddr : bus.s_axi_araddr;

    axi_address_fix_subtractor #(
        .AXI_ADDR_WIDTH (AXI_ADDR_WIDTH),
        .ADDR_OFFSET    (ADDR_OFFSET)
    ) u_addr_fix (
        .i_addr      (w_raw_addr),
        .o_addr      (w_xlat_addr),
        .o_in_window (w_in_window)
    );

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_state          <= ST_IDLE;
            r_last_was_write <= 1'b0;
            r_obi_addr       <= '0;
            r_obi_wdata      <= '0;
            r_obi_be         <= '0;
            r_obi_we         <= 1'b0;
            r_bresp          <= AXI_RESP_OKAY;
            r_rresp          <= AXI_RESP_OKAY;
            r_rdata          <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_take_wr) begin
                        r_last_was_write <= 1'b1;
                        r_obi_addr       <= w_xlat_addr;
                        r_obi_wdata      <= bus.s_axi_wdata;
                        r_obi_be         <= bus.s_axi_wstrb;
                        r_obi_we         <= 1'b1;
                        if (w_in_window) begin
                            r_state <= ST_WR_REQ;
                        end else begin
                            r_state <= ST_WR_RESP;
                            r_bresp <= AXI_RESP_SLVERR;
                        end
                    end else if (w_take_rd) begin
                        r_last_was_write <= 1'b0;
                        r_obi_addr       <= w_xlat_addr;
                        r_obi_be         <= '1;
                        r_obi_we         <= 1'b0;
                        if (w_in_window) begin
                            r_state <= ST_RD_REQ;
                        end else begin
                            r_state <= ST_RD_RESP;
                            r_rresp <= AXI_RESP_SLVERR;
                            r_rdata <= '0;
                        end
                    end
                end
                ST_WR_REQ:  if (bus.obi_gnt) r_state <= ST_WR_WAIT;
                ST_WR_WAIT: begin
                    if (bus.obi_rvalid) begin
                        r_state <= ST_WR_RESP;
                        r_bresp <= AXI_RESP_OKAY;
                    end
                end
                ST_WR_RESP: if (bus.s_axi_bready) r_state <= ST_IDLE;
                ST_RD_REQ:  if (bus.obi_gnt) r_state <= ST_RD_WAIT;
                ST_RD_WAIT: begin
                    if (bus.obi_rvalid) begin
                        r_state <= ST_RD_RESP;
                        r_rresp <= AXI_RESP_OKAY;
                        r_rdata <= bus.obi_rdata;
                    end
                end
                ST_RD_RESP: if (bus.s_axi_rready) r_state <= ST_IDLE;
                default:    r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.s_axi_awready = w_take_wr;
    assign bus.s_axi_wready  = w_take_wr;
    assign bus.s_axi_arready = w_take_rd;
    assign bus.s_axi_bvalid  = (r_state == ST_WR_RESP);
    assign bus.s_axi_bresp   = r_bresp;
    assign bus.s_axi_rvalid  = (r_state == ST_RD_RESP);
    assign bus.s_axi_rresp   = r_rresp;
    assign bus.s_axi_rdata   = r_rdata;

    assign bus.obi_req   = (r_state == ST_WR_REQ) || (r_state == ST_RD_REQ);
    assign bus.obi_addr  = r_obi_addr;
    assign bus.obi_we    = r_obi_we;
    assign bus.obi_be    = r_obi_be;
    assign bus.obi_wdata = r_obi_wdata;
endmodule
`default_nettype wire
